others_seq: RTL and testbench
=============================

Name: others_seq

Overview:
- Sequential, parametrised successor to the combinational "others" unit of the ALU.
- Executes the non-arithmetic miscellaneous ops: pass-through, two's-complement negate and zero, plus new multi-cycle population-count and count-leading-zeros ops.
- Uses valid/ready handshakes on input and output, and adds overflow detection on negate.
- Sits beside the add/sub, bitwise and shift units behind the ALU's FuncCode decoder.

Parameters:
- data_width, 16, operand/result width in bits; legal range 4..64.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present on A/FuncCode.
- in_ready  output  1  unit can accept a request (combinational: state==IDLE).
- A  input  data_width  operand.
- FuncCode  input  4  operation select.
- out_valid  output  1  C/OverflowFlag hold a valid result.
- out_ready  input  1  consumer accepts the result.
- C  output  data_width  result (registered).
- OverflowFlag  output  1  overflow of the returned result (registered).
- busy  output  1  high in CALC.

Behaviour:
- Ops (FuncCode):
  - 0010 TCP: C=A.
  - 1110 NEG: C=~A+1.
  - 1111 ZERO: C=0.
  - 1100 POPCNT: C = number of 1 bits in A.
  - 1101 CLZ: C = number of leading zeros of A; A=0 gives data_width.
  - Any other code: C=0, OverflowFlag=0, treated as single-cycle.
- OverflowFlag:
  - Set to 1 only for NEG when A == 1<<(data_width-1). In that case C equals A (wrapped result).
  - 0 for all other ops and inputs.
- Counts are zero-extended to data_width bits.
- Reset (async assert, sync release): state=IDLE, C=0, OverflowFlag=0, out_valid=0, busy=0, internal shift/count regs=0. While in reset, in_ready=1.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - in_ready=1.
  - A request is accepted on the clk edge where in_valid=1.
  - Single-cycle op: result is registered on the accept edge; state goes to HOLD; out_valid=1 on the next cycle (latency 1).
  - POPCNT/CLZ: shift reg loads A, count=0, index=0; state goes to CALC.
- CALC:
  - One bit is examined per cycle; in_ready=0; busy=1.
  - POPCNT: add the LSB of the shift reg, then shift right. Exactly data_width cycles, then HOLD.
  - CLZ: examine the MSB of the shift reg. If the bit is 0, count++ and shift left. Leave CALC once a 1 is seen or data_width bits have been examined.
  - CLZ time in CALC = min(clz+1, data_width) cycles.
  - Result and OverflowFlag=0 are written on the exit edge.
  - Inputs are ignored while in CALC; the operand is captured at accept.
- HOLD:
  - out_valid=1; C and OverflowFlag are stable and do not change until the handshake.
  - On the edge with out_valid & out_ready: go to IDLE; out_valid=0 next cycle; C keeps its last value.
- Throughput and ordering:
  - No overlap: a new request is accepted only in IDLE, so at most one op is in flight.
  - Single-cycle ops can sustain at best 1 per 2 cycles.
  - Simultaneous out_ready and in_valid in HOLD: only the output handshake completes; in_valid is taken in IDLE on the following cycle.
- Reset mid-CALC or mid-HOLD: the operation is aborted and lost, outputs go to reset values immediately, and no result is produced.
- Back-pressure: out_ready may stay low indefinitely; the unit stays in HOLD with its outputs frozen.

Decomposition:
- Shared package others_pkg holds:
  - FuncCode localparams (OP_TCP=4'b0010, OP_NEG=4'b1110, OP_ZERO=4'b1111, OP_POPCNT=4'b1100, OP_CLZ=4'b1101).
  - FSM state encoding (IDLE=2'd0, CALC=2'd1, HOLD=2'd2).
  - Count-width function clog2(data_width+1).
- One sub-module, others_iter_count:
  - Contains the shift register, bit index and counter for POPCNT/CLZ.
  - Interface: start, mode, operand in; done, count out.
- The top level holds the FSM, the single-cycle datapath and the output registers.

Test Plan:
- Reset held 3 cycles, then released; no in_valid -> C=0, OverflowFlag=0, out_valid=0, in_ready=1, busy=0.
- data_width=16. Accept TCP A=0x1234, then NEG A=0x0001, then NEG A=0x8000, each with out_ready=1 -> in order: C=0x1234/OVF=0, then C=0xFFFF/OVF=0, then C=0x8000/OVF=1; each result has out_valid high exactly 1 cycle after accept.
- POPCNT A=0xF0F1 -> busy for 16 cycles, then C=0x0009, OVF=0. CLZ: A=0x8000 -> C=0, 1 CALC cycle; A=0x0001 -> C=15, 16 cycles; A=0x0000 -> C=16, 16 cycles.
- Unknown FuncCode 4'b0101 with A=0xABCD -> C=0, OVF=0, latency 1. out_ready held low 10 cycles -> out_valid stays 1, C stable, in_ready=0 and in_valid ignored until out_ready.
- Reset asserted mid-CALC during POPCNT (cycle 5) -> outputs 0 immediately, no result emitted. A post-reset ZERO request completes normally with C=0.
- data_width=8 build: POPCNT 0xFF -> C=8 after 8 cycles; NEG 0x80 -> C=0x80, OVF=1.

Source files
------------

// File: rtl/others_pkg.sv
// Shared definitions for the sequential "others" ALU unit: opcodes, FSM
// states and the width of the POPCNT/CLZ counter.
package others_pkg;

  localparam logic [3:0] OP_TCP    = 4'b0010;
  localparam logic [3:0] OP_NEG    = 4'b1110;
  localparam logic [3:0] OP_ZERO   = 4'b1111;
  localparam logic [3:0] OP_POPCNT = 4'b1100;
  localparam logic [3:0] OP_CLZ    = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // A count can reach data_width itself (CLZ of zero, POPCNT of all ones).
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/others_seq_if.sv
// Request/response bundle between the ALU decoder (master) and the
// sequential "others" unit (slave).
interface others_seq_if #(
  parameter int data_width = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] A;
  logic [3:0]            FuncCode;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] C;
  logic                  OverflowFlag;
  logic                  busy;

  modport master (
    output in_valid, A, FuncCode, out_ready,
    input  in_ready, out_valid, C, OverflowFlag, busy
  );

  modport slave (
    input  in_valid, A, FuncCode, out_ready,
    output in_ready, out_valid, C, OverflowFlag, busy
  );

endinterface

// File: rtl/others_seq_iter_count.sv
// Bit-serial counter behind POPCNT (LSB first) and CLZ (MSB first, stops at
// the first 1). done/count are combinational so the caller registers the
// final count on the same edge the last bit is examined.
module others_iter_count
  import others_pkg::*;
#(
  parameter  int data_width = 16,
  localparam int CW         = count_width(data_width)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [data_width-1:0] operand,
  output logic                  done,
  output logic [CW-1:0]         count
);

  localparam logic [CW-1:0] LAST = CW'(data_width - 1);

  logic [data_width-1:0] shift_reg;
  logic [CW-1:0]         index;
  logic [CW-1:0]         cnt;
  logic                  active;
  logic                  mode_q;
  logic                  bit_hit;

  // mode_q=1 is CLZ: a zero at the MSB adds to the count and a one ends it.
  always_comb begin
    bit_hit = mode_q ? ~shift_reg[data_width-1] : shift_reg[0];
    count   = cnt + CW'(bit_hit);
    done    = active && ((index == LAST) || (mode_q && shift_reg[data_width-1]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      index     <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      mode_q    <= 1'b0;
    end else if (start) begin
      shift_reg <= operand;
      index     <= '0;
      cnt       <= '0;
      active    <= 1'b1;
      mode_q    <= mode;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end
      index     <= index + CW'(1);
      cnt       <= count;
      shift_reg <= mode_q ? (shift_reg << 1) : (shift_reg >> 1);
    end
  end

endmodule

// File: rtl/others_seq.sv
// Sequential "others" ALU unit: pass-through, negate with overflow, zero,
// plus multi-cycle POPCNT/CLZ, behind valid/ready handshakes.
module others_seq
  import others_pkg::*;
#(
  parameter int data_width = 16
) (
  input logic        clk,
  input logic        reset,
  others_seq_if.slave bus
);

  localparam int CW = count_width(data_width);
  localparam logic [data_width-1:0] MOST_NEG = {1'b1, {(data_width-1){1'b0}}};

  state_t        state;
  logic          is_iter;
  logic          start;
  logic          mode;
  logic          done;
  logic [CW-1:0] count;

  assign bus.in_ready = (state == IDLE);
  assign is_iter      = (bus.FuncCode == OP_POPCNT) || (bus.FuncCode == OP_CLZ);
  assign start        = (state == IDLE) && bus.in_valid && is_iter;
  assign mode         = (bus.FuncCode == OP_CLZ);

  others_iter_count #(
    .data_width(data_width)
  ) iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .operand(bus.A),
    .done   (done),
    .count  (count)
  );

  // Negating the most negative value wraps back to itself; that is the only overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bus.C            <= '0;
      bus.OverflowFlag <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_iter) begin
              state    <= CALC;
              bus.busy <= 1'b1;
            end else begin
              state         <= HOLD;
              bus.out_valid <= 1'b1;
              case (bus.FuncCode)
                OP_TCP: begin
                  bus.C            <= bus.A;
                  bus.OverflowFlag <= 1'b0;
                end
                OP_NEG: begin
                  bus.C            <= (~bus.A) + data_width'(1);
                  bus.OverflowFlag <= (bus.A == MOST_NEG);
                end
                default: begin
                  bus.C            <= '0;
                  bus.OverflowFlag <= 1'b0;
                end
              endcase
            end
          end
        end
        CALC: begin
          if (done) begin
            state            <= HOLD;
            bus.busy         <= 1'b0;
            bus.out_valid    <= 1'b1;
            bus.C            <= data_width'(count);
            bus.OverflowFlag <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_others_seq.sv
// Directed bench for others_seq: a 16-bit instance for the main tests and an
// 8-bit instance for the narrow-width POPCNT/NEG cases.
module tb_others_seq;
  import others_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   fail_count  = 0;

  always #5 clk = ~clk;

  others_seq_if #(.data_width(16)) bus16 ();
  others_seq_if #(.data_width(8))  bus8 ();

  others_seq #(.data_width(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  others_seq #(.data_width(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds one request on the 16-bit bus for exactly one edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a);
    bus16.in_valid = 1'b1;
    bus16.FuncCode = op;
    bus16.A        = a;
    step();
    bus16.in_valid = 1'b0;
  endtask

  task automatic runSingle(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] exp_c, input logic exp_ovf);
    applyStimulus(op, a);
    checkOutput({tag, "_valid"}, bus16.out_valid, 1);
    checkOutput({tag, "_c"}, bus16.C, exp_c);
    checkOutput({tag, "_ovf"}, bus16.OverflowFlag, exp_ovf);
    step();
    checkOutput({tag, "_drop"}, bus16.out_valid, 0);
  endtask

  task automatic runIter(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] exp_c, input int exp_cycles);
    int cycles;
    applyStimulus(op, a);
    cycles = 0;
    while (bus16.busy && cycles < 200) begin
      cycles++;
      step();
    end
    checkOutput({tag, "_cycles"}, cycles, exp_cycles);
    checkOutput({tag, "_valid"}, bus16.out_valid, 1);
    checkOutput({tag, "_c"}, bus16.C, exp_c);
    checkOutput({tag, "_ovf"}, bus16.OverflowFlag, 0);
    step();
    checkOutput({tag, "_drop"}, bus16.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    int cycles;
    reset          = 1'b1;
    bus16.in_valid = 1'b0;
    bus16.A        = '0;
    bus16.FuncCode = '0;
    bus16.out_ready = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.A         = '0;
    bus8.FuncCode  = '0;
    bus8.out_ready = 1'b0;

    repeat (3) step();
    checkOutput("rst_in_ready", bus16.in_ready, 1);
    checkOutput("rst_c", bus16.C, 0);
    reset = 1'b0;
    step();
    checkOutput("idle_c", bus16.C, 0);
    checkOutput("idle_ovf", bus16.OverflowFlag, 0);
    checkOutput("idle_valid", bus16.out_valid, 0);
    checkOutput("idle_in_ready", bus16.in_ready, 1);
    checkOutput("idle_busy", bus16.busy, 0);

    bus16.out_ready = 1'b1;
    runSingle("tcp_1234", OP_TCP, 16'h1234, 16'h1234, 1'b0);
    runSingle("neg_0001", OP_NEG, 16'h0001, 16'hFFFF, 1'b0);
    runSingle("neg_8000", OP_NEG, 16'h8000, 16'h8000, 1'b1);
    runSingle("neg_7fff", OP_NEG, 16'h7FFF, 16'h8001, 1'b0);

    runIter("popcnt_f0f1", OP_POPCNT, 16'hF0F1, 16'd9, 16);
    runIter("clz_8000", OP_CLZ, 16'h8000, 16'd0, 1);
    runIter("clz_0001", OP_CLZ, 16'h0001, 16'd15, 16);
    runIter("clz_0000", OP_CLZ, 16'h0000, 16'd16, 16);

    // Unknown opcode under back-pressure with a competing request held high.
    bus16.out_ready = 1'b0;
    applyStimulus(4'b0101, 16'hABCD);
    checkOutput("unk_valid", bus16.out_valid, 1);
    checkOutput("unk_c", bus16.C, 0);
    checkOutput("unk_ovf", bus16.OverflowFlag, 0);
    bus16.in_valid = 1'b1;
    bus16.FuncCode = OP_TCP;
    bus16.A        = 16'h1111;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("bp_valid", bus16.out_valid, 1);
      checkOutput("bp_c", bus16.C, 0);
      checkOutput("bp_in_ready", bus16.in_ready, 0);
    end
    bus16.out_ready = 1'b1;
    step();
    checkOutput("bp_release_valid", bus16.out_valid, 0);
    checkOutput("bp_release_c", bus16.C, 0);
    checkOutput("bp_release_in_ready", bus16.in_ready, 1);
    step();
    bus16.in_valid = 1'b0;
    checkOutput("late_tcp_valid", bus16.out_valid, 1);
    checkOutput("late_tcp_c", bus16.C, 16'h1111);
    step();
    checkOutput("late_tcp_drop", bus16.out_valid, 0);

    // Reset in the middle of a POPCNT must abort it without producing a result.
    runSingle("tcp_5a5a", OP_TCP, 16'h5A5A, 16'h5A5A, 1'b0);
    bus16.out_ready = 1'b0;
    applyStimulus(OP_POPCNT, 16'hFFFF);
    repeat (4) step();
    checkOutput("pre_abort_busy", bus16.busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_c", bus16.C, 0);
    checkOutput("abort_busy", bus16.busy, 0);
    checkOutput("abort_valid", bus16.out_valid, 0);
    checkOutput("abort_in_ready", bus16.in_ready, 1);
    checkOutput("abort_ovf", bus16.OverflowFlag, 0);
    step();
    reset = 1'b0;
    bus16.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus16.out_valid) seen++;
    end
    checkOutput("abort_no_result", seen, 0);
    runSingle("zero_3333", OP_ZERO, 16'h3333, 16'h0000, 1'b0);

    // Narrow build.
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.FuncCode  = OP_POPCNT;
    bus8.A         = 8'hFF;
    step();
    bus8.in_valid = 1'b0;
    cycles = 0;
    while (bus8.busy && cycles < 100) begin
      cycles++;
      step();
    end
    checkOutput("w8_popcnt_cycles", cycles, 8);
    checkOutput("w8_popcnt_valid", bus8.out_valid, 1);
    checkOutput("w8_popcnt_c", bus8.C, 8'h08);
    step();
    checkOutput("w8_popcnt_drop", bus8.out_valid, 0);
    bus8.in_valid = 1'b1;
    bus8.FuncCode = OP_NEG;
    bus8.A        = 8'h80;
    step();
    bus8.in_valid = 1'b0;
    checkOutput("w8_neg_valid", bus8.out_valid, 1);
    checkOutput("w8_neg_c", bus8.C, 8'h80);
    checkOutput("w8_neg_ovf", bus8.OverflowFlag, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
